// File: rtl/cmd_rx_if.sv
// rtl/cmd_rx_if.sv - MII receive and command-issue signal bundle for cmd_rx
interface cmd_rx_if;
    logic [3:0]  mii_D;
    logic        mii_DV;
    logic [19:0] command;
    logic [2:0]  opcode;
    logic        strobe;
    logic [7:0]  seqnum;
    logic        tx_strobe;
    logic [7:0]  rx_good;
    logic [7:0]  rx_bad;
    logic        busy;

    modport slave (
        input  mii_D, mii_DV,
        output command, opcode, strobe, seqnum, tx_strobe, rx_good, rx_bad, busy
    );

    modport master (
        output mii_D, mii_DV,
        input  command, opcode, strobe, seqnum, tx_strobe, rx_good, rx_bad, busy
    );
endinterface

// File: rtl/cmd_rx.sv
// rtl/cmd_rx.sv - MII command frame receiver with FCS check and paced toggle-strobe command issue
module cmd_rx #(
    parameter int          NCMD  = 4,
    parameter int          GAP   = 8,
    parameter logic [15:0] ETYPE = 16'h5555
) (
    input  logic     clk,
    input  logic     rst_n,
    cmd_rx_if.slave  bus
);
    localparam int          SW      = $clog2(NCMD + 1);
    localparam int          GW      = $clog2(GAP);
    localparam logic [7:0]  NIB     = 8'(2 * (20 + 4 * NCMD));
    localparam logic [6:0]  WEND    = 7'(16 + 4 * NCMD);
    localparam logic [SW-1:0] SLOT_END = SW'(NCMD);
    localparam logic [GW-1:0] GAP_M1   = GW'(GAP - 1);
    localparam logic [31:0] RESIDUE = 32'hDEBB20E3;

    typedef enum logic [1:0] {S_IDLE, S_PRE, S_BODY, S_DROP} rx_state_t;

    rx_state_t   state;
    logic [3:0]  d_r;
    logic        dv_r;
    logic [7:0]  cnt;
    logic [31:0] crc;
    logic [31:0] crc_nx;
    logic [3:0]  lo_nib;
    logic [7:0]  type_lo;
    logic [7:0]  stage_seq;
    logic [22:0] stage [NCMD];
    logic [22:0] iss [NCMD];

    logic [SW-1:0] slot_q;
    logic [GW-1:0] wait_q;
    logic [22:0]   cur;

    logic [19:0] command_q;
    logic [2:0]  opcode_q;
    logic        strobe_q;
    logic [7:0]  seqnum_q;
    logic        tx_strobe_q;
    logic [7:0]  rx_good_q;
    logic [7:0]  rx_bad_q;
    logic        busy_q;

    logic [6:0] byte_idx;
    logic [6:0] woff;
    logic [7:0] byte_val;
    logic       in_words;
    logic       type_bad;

    // Reflected CRC-32, one bit per step, LSB of the nibble first
    always_comb begin
        crc_nx = crc;
        for (int i = 0; i < 4; i++) begin
            crc_nx = (crc_nx >> 1) ^ (((crc_nx[0] ^ d_r[i]) != 1'b0) ? 32'hEDB88320 : 32'h0);
        end
    end

    always_comb begin
        byte_idx = cnt[7:1];
        woff     = byte_idx - 7'd16;
        byte_val = {d_r, lo_nib};
        in_words = (byte_idx >= 7'd16) && (byte_idx < WEND);
        type_bad = (cnt == 8'd27) && ({byte_val, type_lo} != ETYPE);
    end

    always_comb begin
        cur = '0;
        for (int w = 0; w < NCMD; w++) begin
            if (slot_q == w[SW-1:0]) cur = iss[w];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            d_r         <= '0;
            dv_r        <= 1'b0;
            cnt         <= '0;
            crc         <= '1;
            lo_nib      <= '0;
            type_lo     <= '0;
            stage_seq   <= '0;
            for (int w = 0; w < NCMD; w++) begin
                stage[w] <= '0;
                iss[w]   <= '0;
            end
            slot_q      <= '0;
            wait_q      <= '0;
            command_q   <= '0;
            opcode_q    <= '0;
            strobe_q    <= 1'b0;
            seqnum_q    <= '0;
            tx_strobe_q <= 1'b0;
            rx_good_q   <= '0;
            rx_bad_q    <= '0;
            busy_q      <= 1'b0;
        end else begin
            d_r  <= bus.mii_D;
            dv_r <= bus.mii_DV;

            case (state)
                S_IDLE: begin
                    if (dv_r) state <= (d_r == 4'h5) ? S_PRE : S_DROP;
                end
                S_PRE: begin
                    if (!dv_r) begin
                        state    <= S_IDLE;
                        rx_bad_q <= rx_bad_q + 8'd1;
                    end else if (d_r == 4'hD) begin
                        state <= S_BODY;
                        cnt   <= '0;
                        crc   <= '1;
                    end else if (d_r != 4'h5) begin
                        state <= S_DROP;
                    end
                end
                S_BODY: begin
                    if (dv_r) begin
                        crc <= crc_nx;
                        cnt <= cnt + 8'd1;
                        if (!cnt[0]) begin
                            lo_nib <= d_r;
                        end else begin
                            if (byte_idx == 7'd12) type_lo <= byte_val;
                            if (byte_idx == 7'd14) stage_seq <= byte_val;
                            for (int w = 0; w < NCMD; w++) begin
                                if (in_words && woff[6:2] == w[4:0]) begin
                                    case (woff[1:0])
                                        2'd0:    stage[w][7:0]   <= byte_val;
                                        2'd1:    stage[w][15:8]  <= byte_val;
                                        2'd2:    stage[w][22:16] <= byte_val[6:0];
                                        default: ;
                                    endcase
                                end
                            end
                        end
                        if (type_bad || cnt == NIB) state <= S_DROP;
                    end else begin
                        // Single commit point per frame: either good or bad, never both
                        state <= S_IDLE;
                        if (cnt == NIB && crc == RESIDUE && !busy_q) begin
                            for (int w = 0; w < NCMD; w++) iss[w] <= stage[w];
                            seqnum_q  <= stage_seq;
                            rx_good_q <= rx_good_q + 8'd1;
                            busy_q    <= 1'b1;
                            slot_q    <= '0;
                            wait_q    <= '0;
                        end else begin
                            rx_bad_q <= rx_bad_q + 8'd1;
                        end
                    end
                end
                S_DROP: begin
                    if (!dv_r) begin
                        state    <= S_IDLE;
                        rx_bad_q <= rx_bad_q + 8'd1;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (busy_q) begin
                if (wait_q != '0) begin
                    wait_q <= wait_q - 1'b1;
                end else if (slot_q == SLOT_END) begin
                    tx_strobe_q <= ~tx_strobe_q;
                    busy_q      <= 1'b0;
                    slot_q      <= '0;
                end else begin
                    slot_q <= slot_q + 1'b1;
                    if (cur[22:20] != 3'd0) begin
                        command_q <= cur[19:0];
                        opcode_q  <= cur[22:20];
                        strobe_q  <= ~strobe_q;
                        wait_q    <= GAP_M1;
                    end
                end
            end
        end
    end

    assign bus.command   = command_q;
    assign bus.opcode    = opcode_q;
    assign bus.strobe    = strobe_q;
    assign bus.seqnum    = seqnum_q;
    assign bus.tx_strobe = tx_strobe_q;
    assign bus.rx_good   = rx_good_q;
    assign bus.rx_bad    = rx_bad_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_cmd_rx.sv
// tb/tb_cmd_rx.sv - directed, table-driven bench for cmd_rx
module tb_cmd_rx;
    logic clk;
    logic rst_n;

    cmd_rx_if bus();
    cmd_rx_if bus_s();

    assign bus_s.mii_D  = bus.mii_D;
    assign bus_s.mii_DV = bus.mii_DV;

    cmd_rx #(.NCMD(4), .GAP(8), .ETYPE(16'h5555)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    // Long-gap copy so a following frame can finish while the first is still issuing
    cmd_rx #(.NCMD(4), .GAP(40), .ETYPE(16'h5555)) dut_s (
        .clk(clk), .rst_n(rst_n), .bus(bus_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic             rst;
        logic [7:0]       seq;
        logic [15:0]      etype;
        logic [3:0][31:0] w;
        int               flip;
        int               nib_adj;
        logic             bad_pre;
        int               e_stb;
        int               e_tx;
        logic [7:0]       e_seq;
        logic [7:0]       e_good;
        logic [7:0]       e_bad;
        logic [2:0]       e_op;
        logic [19:0]      e_cmd;
    } vec_t;

    localparam logic [3:0][31:0] W0 = {32'h0, 32'h0, 32'h0060_0100, 32'h0050_0003};
    localparam logic [3:0][31:0] WZ = {32'h0, 32'h0, 32'h0, 32'h0};
    localparam logic [3:0][31:0] W7 = {32'h0020_0007, 32'h0, 32'h0, 32'hFFF1_2345};
    localparam logic [3:0][31:0] WA = {32'h0040_0004, 32'h0030_0003, 32'h0020_0002, 32'h0010_0001};

    vec_t vt [8];

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    int          stb_t [$];
    logic [22:0] stb_v [$];
    int          tx_t [$];
    int          s_stb_n, s_tx_n;
    logic        sp, tp, ssp, stp;

    logic [7:0] fb [$];
    logic [3:0] nq [$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            sp = 1'b0; tp = 1'b0; ssp = 1'b0; stp = 1'b0;
        end else begin
            if (bus.strobe !== sp) begin
                stb_t.push_back(cyc);
                stb_v.push_back({bus.opcode, bus.command});
                sp = bus.strobe;
            end
            if (bus.tx_strobe !== tp) begin
                tx_t.push_back(cyc);
                tp = bus.tx_strobe;
            end
            if (bus_s.strobe !== ssp) begin
                s_stb_n++;
                ssp = bus_s.strobe;
            end
            if (bus_s.tx_strobe !== stp) begin
                s_tx_n++;
                stp = bus_s.tx_strobe;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        stb_t.delete(); stb_v.delete(); tx_t.delete();
        s_stb_n = 0; s_tx_n = 0;
        rst_n = 1'b1;
    endtask

    task automatic build(input vec_t v);
        logic [31:0] c;
        logic [7:0]  b;
        fb.delete();
        nq.delete();
        for (int j = 0; j < 6; j++) fb.push_back(8'hFF);
        for (int j = 0; j < 6; j++) fb.push_back(8'h10 + 8'(j));
        fb.push_back(v.etype[7:0]);
        fb.push_back(v.etype[15:8]);
        fb.push_back(v.seq);
        fb.push_back(8'h00);
        for (int w = 0; w < 4; w++)
            for (int k = 0; k < 4; k++) fb.push_back(v.w[w][8*k +: 8]);
        c = 32'hFFFF_FFFF;
        foreach (fb[i]) begin
            b = fb[i];
            for (int j = 0; j < 8; j++)
                c = (c >> 1) ^ (((c[0] ^ b[j]) != 1'b0) ? 32'hEDB8_8320 : 32'h0);
        end
        c = ~c;
        for (int j = 0; j < 4; j++) fb.push_back(c[8*j +: 8]);
        if (v.flip >= 0) begin
            b = fb[v.flip / 8];
            b[v.flip % 8] = ~b[v.flip % 8];
            fb[v.flip / 8] = b;
        end
        for (int i = 0; i < 15; i++) nq.push_back((v.bad_pre && i == 3) ? 4'h7 : 4'h5);
        nq.push_back(4'hD);
        foreach (fb[i]) begin
            b = fb[i];
            nq.push_back(b[3:0]);
            nq.push_back(b[7:4]);
        end
        if (v.nib_adj < 0) repeat (-v.nib_adj) void'(nq.pop_back());
        else repeat (v.nib_adj) nq.push_back(4'h0);
    endtask

    task automatic send();
        foreach (nq[i]) begin
            @(negedge clk);
            bus.mii_D  = nq[i];
            bus.mii_DV = 1'b1;
        end
        @(negedge clk);
        bus.mii_DV = 1'b0;
        bus.mii_D  = 4'h0;
    endtask

    initial begin
        vec_t v;
        rst_n = 1'b0;
        bus.mii_D = 4'h0;
        bus.mii_DV = 1'b0;
        s_stb_n = 0; s_tx_n = 0;

        //        rst   seq    etype     w   flip nib pre  stb tx seq    good   bad    op    cmd
        vt[0] = '{1'b1, 8'h2A, 16'h5555, W0, -1,   0, 1'b0, 2, 1, 8'h2A, 8'd1, 8'd0, 3'd6, 20'h00100};
        vt[1] = '{1'b1, 8'h2A, 16'h5555, W0, 128,  0, 1'b0, 0, 0, 8'h00, 8'd0, 8'd1, 3'd0, 20'h00000};
        vt[2] = '{1'b1, 8'h2A, 16'h5555, W0, -1,  -2, 1'b0, 0, 0, 8'h00, 8'd0, 8'd1, 3'd0, 20'h00000};
        vt[3] = '{1'b0, 8'h2A, 16'h5555, W0, -1,   2, 1'b0, 0, 0, 8'h00, 8'd0, 8'd2, 3'd0, 20'h00000};
        vt[4] = '{1'b1, 8'h2A, 16'h5455, W0, -1,   0, 1'b0, 0, 0, 8'h00, 8'd0, 8'd1, 3'd0, 20'h00000};
        vt[5] = '{1'b1, 8'h2A, 16'h5555, W0, -1,   0, 1'b1, 0, 0, 8'h00, 8'd0, 8'd1, 3'd0, 20'h00000};
        vt[6] = '{1'b1, 8'h11, 16'h5555, WZ, -1,   0, 1'b0, 0, 1, 8'h11, 8'd1, 8'd0, 3'd0, 20'h00000};
        vt[7] = '{1'b1, 8'h33, 16'h5555, W7, -1,   0, 1'b0, 2, 1, 8'h33, 8'd1, 8'd0, 3'd2, 20'h00007};

        repeat (2) @(negedge clk);
        chk("reset command", 32'(bus.command), 32'h0);
        chk("reset opcode", 32'(bus.opcode), 32'h0);
        chk("reset strobe", 32'(bus.strobe), 32'h0);
        chk("reset seqnum", 32'(bus.seqnum), 32'h0);
        chk("reset tx_strobe", 32'(bus.tx_strobe), 32'h0);
        chk("reset rx_good", 32'(bus.rx_good), 32'h0);
        chk("reset rx_bad", 32'(bus.rx_bad), 32'h0);
        chk("reset busy", 32'(bus.busy), 32'h0);
        do_reset();

        for (int i = 0; i < 8; i++) begin
            v = vt[i];
            if (v.rst) do_reset();
            build(v);
            send();
            repeat (50) @(negedge clk);
            chk($sformatf("v%0d strobes", i), 32'(stb_t.size()), 32'(v.e_stb));
            chk($sformatf("v%0d tx toggles", i), 32'(tx_t.size()), 32'(v.e_tx));
            chk($sformatf("v%0d seqnum", i), 32'(bus.seqnum), 32'(v.e_seq));
            chk($sformatf("v%0d rx_good", i), 32'(bus.rx_good), 32'(v.e_good));
            chk($sformatf("v%0d rx_bad", i), 32'(bus.rx_bad), 32'(v.e_bad));
            chk($sformatf("v%0d opcode", i), 32'(bus.opcode), 32'(v.e_op));
            chk($sformatf("v%0d command", i), 32'(bus.command), 32'(v.e_cmd));
            chk($sformatf("v%0d busy", i), 32'(bus.busy), 32'h0);
        end

        // Strobe pacing and tx_strobe placement for the reference frame
        do_reset();
        build(vt[0]);
        send();
        repeat (50) @(negedge clk);
        chk("pace strobe count", 32'(stb_t.size()), 32'd2);
        if (stb_t.size() >= 2 && tx_t.size() >= 1) begin
            chk("pace first cmd", 32'(stb_v[0]), 32'({3'd5, 20'd3}));
            chk("pace second cmd", 32'(stb_v[1]), 32'({3'd6, 20'h00100}));
            chk("pace strobe gap", 32'(stb_t[1] - stb_t[0]), 32'd8);
            chk("pace tx after last", 32'(tx_t[0] - stb_t[1]), 32'd10);
        end else begin
            chk("pace toggles present", 32'(stb_t.size() * 16 + tx_t.size()), 32'd33);
        end

        // Second frame ends while the long-gap copy is still issuing the first
        do_reset();
        v = vt[0];
        v.w = WA;
        build(v);
        send();
        v.seq = 8'h77;
        build(v);
        send();
        repeat (250) @(negedge clk);
        chk("ovl slow strobes", 32'(s_stb_n), 32'd4);
        chk("ovl slow tx", 32'(s_tx_n), 32'd1);
        chk("ovl slow seqnum", 32'(bus_s.seqnum), 32'h2A);
        chk("ovl slow rx_good", 32'(bus_s.rx_good), 32'd1);
        chk("ovl slow rx_bad", 32'(bus_s.rx_bad), 32'd1);
        chk("ovl slow last cmd", 32'({bus_s.opcode, bus_s.command}), 32'({3'd4, 20'd4}));
        chk("ovl fast strobes", 32'(stb_t.size()), 32'd8);
        chk("ovl fast tx", 32'(tx_t.size()), 32'd2);
        chk("ovl fast seqnum", 32'(bus.seqnum), 32'h77);
        chk("ovl fast rx_good", 32'(bus.rx_good), 32'd2);
        chk("ovl fast rx_bad", 32'(bus.rx_bad), 32'd0);

        // Reset after the first strobe abandons the rest of the issue
        do_reset();
        build(vt[0]);
        send();
        for (int k = 0; k < 300 && stb_t.size() < 1; k++) @(negedge clk);
        chk("mid first strobe seen", 32'(stb_t.size()), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid async strobe", 32'(bus.strobe), 32'h0);
        chk("mid async command", 32'(bus.command), 32'h0);
        chk("mid async opcode", 32'(bus.opcode), 32'h0);
        chk("mid async seqnum", 32'(bus.seqnum), 32'h0);
        chk("mid async rx_good", 32'(bus.rx_good), 32'h0);
        chk("mid async busy", 32'(bus.busy), 32'h0);
        repeat (2) @(negedge clk);
        stb_t.delete(); stb_v.delete(); tx_t.delete();
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        chk("mid no strobe", 32'(stb_t.size()), 32'd0);
        chk("mid no tx", 32'(tx_t.size()), 32'd0);
        chk("mid tx level", 32'(bus.tx_strobe), 32'h0);
        build(vt[0]);
        send();
        repeat (50) @(negedge clk);
        chk("after strobes", 32'(stb_t.size()), 32'd2);
        chk("after tx", 32'(tx_t.size()), 32'd1);
        chk("after rx_good", 32'(bus.rx_good), 32'd1);
        chk("after seqnum", 32'(bus.seqnum), 32'h2A);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/cmd_rx.md
Name: cmd_rx

Overview:
- MII receive-side command decoder, the inbound counterpart of the MII reply transmitter.
- Takes nibble-wide MII frames, checks preamble/SFD, header, fixed length and Ethernet FCS, and buffers the command words.
- Only after the FCS passes does it issue the commands one at a time on toggle-strobe outputs (command/opcode/strobe, seqnum).
- After the last command it toggles tx_strobe so the transmitter sends the reply frame.

Parameters:
- NCMD, 4, command words per frame (1..8).
- GAP, 8, clk cycles between successive command strobe toggles (>=2).
- ETYPE, 16'h5555, required EtherType (two bytes on the wire, first-sent byte in bits [7:0]).

Ports:
- clk  in  1  clock; all logic on posedge.
- rst_n  in  1  asynchronous active-low reset.
- mii_D  in  4  receive nibble, low nibble of each byte first.
- mii_DV  in  1  receive data valid.
- command  out  20  command argument, stable while strobe is unchanged.
- opcode  out  3  command opcode.
- strobe  out  1  toggles once per issued command.
- seqnum  out  8  sequence byte of the last good frame.
- tx_strobe  out  1  toggles once per good frame, after all its commands are issued.
- rx_good  out  8  good-frame count (wraps).
- rx_bad  out  8  bad/dropped-frame count, including overruns (wraps).
- busy  out  1  high while issuing commands.

Behaviour:
- Reset (async assert, sync release): state IDLE; command=0, opcode=0, strobe=0, seqnum=0, tx_strobe=0, rx_good=0, rx_bad=0, busy=0; buffer cleared. Reset mid-frame or mid-issue abandons everything: no further toggles and no counter updates.
- Inputs are registered once (1 cycle latency); all decode uses the registered DV and nibble.
- Wire bytes after SFD: dst[6] (ignored), src[6] (ignored), type[2], seq[2] (byte 0 = seqnum, byte 1 ignored), NCMD x 4-byte little-endian words, FCS[4]. Total L = 20+4*NCMD bytes = 2L nibbles.
- Command word layout: [19:0] command, [22:20] opcode, [31:23] ignored. Opcode 0 is a no-op: stored but never issued.
- Receive FSM:
  - IDLE: on DV with nibble 5 -> PRE; on DV with any other nibble -> DROP.
  - PRE: nibble 5 stays in PRE; nibble D -> BODY (nibble count=0, CRC=32'hFFFFFFFF); any other nibble -> DROP; DV low -> IDLE, counted bad.
  - BODY: each DV cycle advances the CRC over the nibble with the reflected polynomial 32'hEDB88320, LSB first, 4 bits per cycle. The nibble count increments; bytes are assembled into the staging buffer.
  - Type check happens when its 4 nibbles complete. Mismatch -> DROP.
  - Frame is good at DV fall only if count == 2L and CRC == 32'hDEBB20E3 (residue over data plus FCS).
  - Count > 2L -> DROP immediately. Short frame or bad CRC at DV fall -> bad.
  - DROP: waits for DV low, then rx_bad+1 and -> IDLE.
- Good frame:
  - Staging buffer copied to the issue buffer; seqnum updated; rx_good+1; busy=1 the next cycle.
  - If busy was already 1 at that DV fall, the frame is discarded instead: rx_bad+1, buffers and seqnum untouched.
- Issue sequencer:
  - Walks slots 0..NCMD-1. For each nonzero opcode it drives command/opcode and toggles strobe in the same cycle, then waits GAP cycles before the next slot.
  - No-op slots take 1 cycle each.
  - After the last slot, tx_strobe toggles and busy drops in the same cycle.
  - A frame with all no-ops still toggles tx_strobe exactly once.
- The receiver keeps parsing while busy; only the commit is blocked. rx_bad and rx_good never increment in the same cycle; this holds by construction, since there is one commit point per frame.
- Counters wrap at 255 to 0.

Test Plan:
- NCMD=4, GAP=8, good frame with seq=8'h2A, words {op5,cmd 3},{op6,cmd 10'h100},{0},{0} -> strobe toggles twice, 8 cycles apart, with (5,3) then (6,20'h00100); tx_strobe toggles once; seqnum=2A; rx_good=1; rx_bad=0.
- Same frame with one payload bit flipped -> no strobe or tx_strobe toggle; seqnum stays 0; rx_bad=1.
- Frame truncated by 2 nibbles, and another with 2 extra nibbles -> both bad; rx_bad=2; outputs unchanged.
- Type bytes 55 54 -> DROP; rx_bad=1. Preamble containing nibble 7 -> DROP; rx_bad=1.
- Second good frame whose DV fall lands while busy -> first frame's toggles complete normally; second frame discarded; rx_bad=1; rx_good=1.
- rst_n pulsed low after the first strobe toggle -> all outputs 0 immediately; no tx_strobe toggle; a fresh good frame afterwards issues normally.
